canvas_draw_sequencer: RTL and testbench

//  Turns per-frame cursor hits and the selected tool, colour and clear request into a

---
 rtl/canvas_pkg.sv | 37 +++
 rtl/canvas_line_stepper.sv | 73 +++++++
 rtl/canvas_draw_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_canvas_draw_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared shape codes, canvas geometry, state encodings and addressing helper
// for the canvas drawing sequencer.
package canvas_pkg;

  localparam logic [2:0] SH_DOT  = 3'd1;
  localparam logic [2:0] SH_LINE = 3'd2;
  localparam logic [2:0] SH_RECT = 3'd3;
  localparam logic [2:0] SH_TRI  = 3'd4;

  localparam int unsigned CANVAS_W = 720;
  localparam int unsigned CANVAS_H = 600;

  localparam logic [15:0] COL_TRANSPARENT = 16'h0000;
  localparam logic [15:0] COL_RESET       = 16'hFFE0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOT,
    ST_ARMED,
    ST_WAIT_B,
    ST_DRAW_LINE,
    ST_DRAW_RECT,
    ST_CLEAR
  } state_e;

  typedef enum logic [1:0] {
    RP_TOP,
    RP_BOTTOM,
    RP_LEFT,
    RP_RIGHT
  } rect_phase_e;

  function automatic logic [19:0] pixel_addr(input logic [9:0] x, input logic [9:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/canvas_line_stepper.sv
// Bresenham line core: loads endpoints on start and advances one pixel per
// accepted write until the end point is presented (last).
module canvas_line_stepper (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic       step,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       last
);
  logic [9:0]         x_q, y_q, xe_q, ye_q, x_d, y_d;
  logic signed [11:0] dx_q, dy_q, err_q, err_d, adx, ady;
  logic signed [12:0] e2, dx_ext, dy_ext;
  logic               sx_q, sy_q;

  // dx is kept non-negative and dy non-positive, so err stays well inside 12 bits.
  always_comb begin
    adx    = (x1 >= x0) ? {2'b00, x1 - x0} : {2'b00, x0 - x1};
    ady    = (y1 >= y0) ? {2'b00, y1 - y0} : {2'b00, y0 - y1};
    e2     = {err_q, 1'b0};
    dx_ext = {dx_q[11], dx_q};
    dy_ext = {dy_q[11], dy_q};
    err_d  = err_q;
    x_d    = x_q;
    y_d    = y_q;
    if (e2 >= dy_ext) begin
      err_d = err_d + dy_q;
      x_d   = sx_q ? x_q - 10'd1 : x_q + 10'd1;
    end
    if (e2 <= dx_ext) begin
      err_d = err_d + dx_q;
      y_d   = sy_q ? y_q - 10'd1 : y_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
    end else if (start) begin
      x_q   <= x0;
      y_q   <= y0;
      xe_q  <= x1;
      ye_q  <= y1;
      dx_q  <= adx;
      dy_q  <= -ady;
      err_q <= adx - ady;
      sx_q  <= (x1 < x0);
      sy_q  <= (y1 < y0);
    end else if (step && !last) begin
      x_q   <= x_d;
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/canvas_draw_sequencer.sv
// Cursor-driven drawing front end: converts per-frame cursor hits, tool and
// colour selection into single-pixel frame-buffer write requests.
module canvas_draw_sequencer #(
  parameter int unsigned CANVAS_W    = canvas_pkg::CANVAS_W,
  parameter int unsigned CANVAS_H    = canvas_pkg::CANVAS_H,
  parameter int unsigned RELEASE_FRM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_end,
  input  logic        i_hit,
  input  logic [12:0] i_cur_x,
  input  logic [12:0] i_cur_y,
  input  logic [2:0]  i_shape,
  input  logic [15:0] i_color,
  input  logic        i_clear,
  output logic        o_wr_req,
  output logic [19:0] o_wr_addr,
  output logic [15:0] o_wr_data,
  input  logic        i_wr_ack,
  output logic        o_busy,
  output logic        o_anchor_vld,
  output logic [9:0]  o_anchor_x,
  output logic [9:0]  o_anchor_y
);
  import canvas_pkg::*;

  localparam logic [12:0] W13    = 13'(CANVAS_W);
  localparam logic [12:0] H13    = 13'(CANVAS_H);
  localparam logic [9:0]  X_LAST = 10'(CANVAS_W - 1);
  localparam logic [9:0]  Y_LAST = 10'(CANVAS_H - 1);
  localparam logic [7:0]  REL    = 8'(RELEASE_FRM);

  state_e      state_q;
  rect_phase_e phase_q;
  logic [7:0]  miss_q;
  logic        clr_q, req_q;
  logic [2:0]  shape_q;
  logic [15:0] color_q, data_q;
  logic [9:0]  ax_q, ay_q, px_q, py_q, rx0_q, rx1_q, ry0_q, ry1_q;
  logic [9:0]  cx, cy, xmin, xmax, ymin, ymax, ln_x, ln_y;
  logic        hit, miss, clr_rise, done, ln_start, ln_step, ln_last, rect_tall;

  assign cx        = i_cur_x[9:0];
  assign cy        = i_cur_y[9:0];
  assign hit       = i_frame_end & i_hit & (i_cur_x < W13) & (i_cur_y < H13);
  assign miss      = i_frame_end & ~hit;
  assign clr_rise  = i_clear & ~clr_q;
  assign done      = req_q & i_wr_ack;
  assign xmin      = (ax_q < cx) ? ax_q : cx;
  assign xmax      = (ax_q < cx) ? cx : ax_q;
  assign ymin      = (ay_q < cy) ? ay_q : cy;
  assign ymax      = (ay_q < cy) ? cy : ay_q;
  assign rect_tall = (ry1_q - ry0_q) > 10'd1;
  assign ln_start  = (state_q == ST_WAIT_B) & ~clr_rise & hit &
                     (i_shape == shape_q) & (shape_q == SH_LINE);
  assign ln_step   = (state_q == ST_DRAW_LINE) & done;

  canvas_line_stepper u_line (
    .clk   (clk),
    .rst   (rst),
    .start (ln_start),
    .x0    (ax_q),
    .y0    (ay_q),
    .x1    (cx),
    .y1    (cy),
    .step  (ln_step),
    .x     (ln_x),
    .y     (ln_y),
    .last  (ln_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= RP_TOP;
      miss_q  <= '0;
      clr_q   <= 1'b0;
      req_q   <= 1'b0;
      shape_q <= SH_LINE;
      color_q <= COL_RESET;
      data_q  <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
      ry0_q   <= '0;
      ry1_q   <= '0;
    end else begin
      clr_q <= i_clear;
      if (hit)                        miss_q <= '0;
      else if (miss && miss_q != REL) miss_q <= miss_q + 8'd1;

      if (clr_rise) begin
        state_q <= ST_CLEAR;
        req_q   <= 1'b0;
        px_q    <= '0;
        py_q    <= '0;
        data_q  <= COL_TRANSPARENT;
      end else begin
        case (state_q)
          ST_IDLE: if (hit) begin
            if (i_shape == SH_DOT) begin
              state_q <= ST_DOT;
              px_q    <= cx;
              py_q    <= cy;
              data_q  <= color_q;
              req_q   <= 1'b1;
            end else if (i_shape == SH_LINE || i_shape == SH_RECT) begin
              state_q <= ST_ARMED;
              ax_q    <= cx;
              ay_q    <= cy;
              shape_q <= i_shape;
            end
          end
          ST_DOT: if (done) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
          ST_ARMED: begin
            if (i_shape != shape_q)  state_q <= ST_IDLE;
            else if (miss_q == REL)  state_q <= ST_WAIT_B;
          end
          ST_WAIT_B: begin
            if (i_shape != shape_q) begin
              state_q <= ST_IDLE;
            end else if (hit) begin
              color_q <= i_color;
              data_q  <= i_color;
              req_q   <= 1'b1;
              if (shape_q == SH_LINE) begin
                state_q <= ST_DRAW_LINE;
              end else begin
                state_q <= ST_DRAW_RECT;
                phase_q <= RP_TOP;
                rx0_q   <= xmin;
                rx1_q   <= xmax;
                ry0_q   <= ymin;
                ry1_q   <= ymax;
                px_q    <= xmin;
                py_q    <= ymin;
              end
            end
          end
          ST_DRAW_LINE: if (done && ln_last) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
          // Perimeter walk: top, bottom, then the inner spans of left and right columns.
          ST_DRAW_RECT: if (done) begin
            case (phase_q)
              RP_TOP: begin
                if (px_q != rx1_q) px_q <= px_q + 10'd1;
                else if (ry1_q != ry0_q) begin
                  phase_q <= RP_BOTTOM;
                  px_q    <= rx0_q;
                  py_q    <= ry1_q;
                end else begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
              RP_BOTTOM: begin
                if (px_q != rx1_q) px_q <= px_q + 10'd1;
                else if (rect_tall) begin
                  phase_q <= RP_LEFT;
                  px_q    <= rx0_q;
                  py_q    <= ry0_q + 10'd1;
                end else begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
              RP_LEFT: begin
                if (py_q != ry1_q - 10'd1) py_q <= py_q + 10'd1;
                else if (rx1_q != rx0_q) begin
                  phase_q <= RP_RIGHT;
                  px_q    <= rx1_q;
                  py_q    <= ry0_q + 10'd1;
                end else begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
              default: begin
                if (py_q != ry1_q - 10'd1) py_q <= py_q + 10'd1;
                else begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
            endcase
          end
          ST_CLEAR: begin
            if (!req_q) req_q <= 1'b1;
            else if (done) begin
              if (px_q != X_LAST) px_q <= px_q + 10'd1;
              else begin
                px_q <= '0;
                if (py_q != Y_LAST) py_q <= py_q + 10'd1;
                else begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_wr_req     = req_q;
  assign o_wr_addr    = (state_q == ST_DRAW_LINE) ? pixel_addr(ln_x, ln_y) : pixel_addr(px_q, py_q);
  assign o_wr_data    = data_q;
  assign o_busy       = (state_q == ST_DRAW_LINE) || (state_q == ST_DRAW_RECT) || (state_q == ST_CLEAR);
  assign o_anchor_vld = (state_q == ST_ARMED) || (state_q == ST_WAIT_B);
  assign o_anchor_x   = ax_q;
  assign o_anchor_y   = ay_q;

endmodule

// File: tb/tb_canvas_draw_sequencer.sv
// Scoreboard bench: stimulus pushes expected pixel writes from a geometric
// reference model; a negedge monitor pops and compares each accepted write.
module tb_canvas_draw_sequencer;
  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_frame_end = 1'b0, i_hit = 1'b0, i_clear = 1'b0, i_wr_ack;
  logic [12:0] i_cur_x = '0, i_cur_y = '0;
  logic [2:0]  i_shape = 3'd1;
  logic [15:0] i_color = 16'h1234;
  logic        o_wr_req, o_busy, o_anchor_vld;
  logic [19:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic [9:0]  o_anchor_x, o_anchor_y;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    bit          busy;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_mode = 0;
  bit          allow_drop = 1'b0;
  logic [15:0] model_color = 16'hFFE0;

  canvas_draw_sequencer #(.CANVAS_W(W), .CANVAS_H(H), .RELEASE_FRM(3)) dut (
    .clk(clk), .rst(rst), .i_frame_end(i_frame_end), .i_hit(i_hit),
    .i_cur_x(i_cur_x), .i_cur_y(i_cur_y), .i_shape(i_shape), .i_color(i_color),
    .i_clear(i_clear), .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ack(i_wr_ack), .o_busy(o_busy), .o_anchor_vld(o_anchor_vld),
    .o_anchor_x(o_anchor_x), .o_anchor_y(o_anchor_y)
  );

  initial forever #5 clk = ~clk;

  function automatic void push_pix(int x, int y, logic [15:0] c, bit b);
    exp_t e;
    e.addr = {10'(y), 10'(x)};
    e.data = c;
    e.busy = b;
    exp_q.push_back(e);
  endfunction

  function automatic void push_line(int x0, int y0, int x1, int y1, logic [15:0] c);
    int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    int dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    int sx = (x0 < x1) ? 1 : -1;
    int sy = (y0 < y1) ? 1 : -1;
    int err = dx + dy;
    int x = x0;
    int y = y0;
    int e2;
    forever begin
      push_pix(x, y, c, 1'b1);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  function automatic void push_rect(int ax, int ay, int bx, int by, logic [15:0] c);
    int x0 = (ax < bx) ? ax : bx;
    int x1 = (ax < bx) ? bx : ax;
    int y0 = (ay < by) ? ay : by;
    int y1 = (ay < by) ? by : ay;
    for (int x = x0; x <= x1; x++) push_pix(x, y0, c, 1'b1);
    if (y1 != y0) for (int x = x0; x <= x1; x++) push_pix(x, y1, c, 1'b1);
    for (int y = y0 + 1; y < y1; y++) push_pix(x0, y, c, 1'b1);
    if (x1 != x0) for (int y = y0 + 1; y < y1; y++) push_pix(x1, y, c, 1'b1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic frame(input bit h, input int x, input int y);
    i_frame_end = 1'b1;
    i_hit       = h;
    i_cur_x     = 13'(x);
    i_cur_y     = 13'(y);
    tick();
    i_frame_end = 1'b0;
    i_hit       = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || o_wr_req) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_req_idle"}, {31'd0, o_wr_req}, 0);
    exp_q.delete();
    tick();
    chk({name, "_busy_idle"}, {31'd0, o_busy}, 0);
  endtask

  task automatic two_point(input string name, input logic [2:0] sh, input int ax, input int ay,
                           input int bx, input int by, input logic [15:0] c, input bit extra_hit);
    i_shape = sh;
    frame(1'b1, ax, ay);
    chk({name, "_anchor_vld"}, {31'd0, o_anchor_vld}, 1);
    chk({name, "_anchor_xy"}, {12'd0, o_anchor_y, o_anchor_x}, {12'd0, 10'(ay), 10'(ax)});
    if (extra_hit) frame(1'b1, bx, by);
    repeat (3) frame(1'b0, 0, 0);
    i_color = c;
    if (sh == 3'd2) push_line(ax, ay, bx, by, c);
    else            push_rect(ax, ay, bx, by, c);
    frame(1'b1, bx, by);
    model_color = c;
    drain(name, 8000);
    chk({name, "_anchor_after"}, {31'd0, o_anchor_vld}, 0);
  endtask

  // Ack driver: 0 = always, 1 = three low cycles per pixel, 2 = random, else held low.
  initial begin
    int wc = 0;
    i_wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: i_wr_ack = 1'b1;
        1: begin
          if (o_wr_req) begin
            if (wc == 3) begin i_wr_ack = 1'b1; wc = 0; end
            else begin i_wr_ack = 1'b0; wc++; end
          end else begin
            i_wr_ack = 1'b0;
            wc = 0;
          end
        end
        2: i_wr_ack = 1'($urandom_range(0, 1));
        default: i_wr_ack = 1'b0;
      endcase
    end
  end

  // Monitor: compares accepted writes against the scoreboard and checks hold stability.
  initial begin
    bit          prev_stall = 1'b0;
    logic [19:0] pa = '0;
    logic [15:0] pd = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (prev_stall && !allow_drop) begin
        checks++;
        if (o_wr_req !== 1'b1 || o_wr_addr !== pa || o_wr_data !== pd) begin
          errors++;
          $display("FAIL hold_stable: req=%b addr=%h data=%h, required req=1 addr=%h data=%h",
                   o_wr_req, o_wr_addr, o_wr_data, pa, pd);
        end
      end
      if (o_wr_req === 1'b1 && i_wr_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", o_wr_addr, o_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (o_wr_addr !== e.addr || o_wr_data !== e.data || (e.busy && o_busy !== 1'b1)) begin
            errors++;
            $display("FAIL pixel_write: addr=%h data=%h busy=%b, required addr=%h data=%h busy=%b",
                     o_wr_addr, o_wr_data, o_busy, e.addr, e.data, e.busy);
          end
        end
      end
      prev_stall = (o_wr_req === 1'b1) && (i_wr_ack !== 1'b1);
      pa = o_wr_addr;
      pd = o_wr_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_req", {31'd0, o_wr_req}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_anchor", {31'd0, o_anchor_vld}, 0);
    chk("rst_addr_data", {o_wr_data[11:0], o_wr_addr}, 0);
    chk("rst_anchor_xy", {12'd0, o_anchor_y, o_anchor_x}, 0);
    rst = 1'b1;
    tick();

    // Dot in reset colour; i_color must not be used.
    ack_mode = 0;
    i_shape  = 3'd1;
    push_pix(100, 50, model_color, 1'b0);
    frame(1'b1, 100, 50);
    drain("t1_dot", 50);

    two_point("t2_rect", 3'd3, 10, 20, 13, 22, 16'h8421, 1'b0);

    // Line with literal expected points, then again with a slow acknowledger.
    for (int pass = 0; pass < 2; pass++) begin
      ack_mode = pass;
      i_shape  = 3'd2;
      frame(1'b1, 0, 0);
      repeat (3) frame(1'b0, 0, 0);
      i_color = 16'h03E0;
      push_pix(0, 0, 16'h03E0, 1'b1); push_pix(1, 0, 16'h03E0, 1'b1);
      push_pix(2, 1, 16'h03E0, 1'b1); push_pix(3, 1, 16'h03E0, 1'b1);
      push_pix(4, 2, 16'h03E0, 1'b1); push_pix(5, 2, 16'h03E0, 1'b1);
      frame(1'b1, 5, 2);
      model_color = 16'h03E0;
      drain(pass == 0 ? "t3_line" : "t3_line_slow", 200);
    end
    ack_mode = 0;

    // Out-of-canvas hits are ignored; shape change in WAIT_B abandons the anchor.
    i_shape = 3'd1;
    frame(1'b1, 730, 5);
    frame(1'b1, W, 0);
    frame(1'b1, 0, H);
    chk("t4_offcanvas_busy", {31'd0, o_busy}, 0);
    i_shape = 3'd3;
    frame(1'b1, 730, 5);
    chk("t4_offcanvas_anchor", {31'd0, o_anchor_vld}, 0);
    frame(1'b1, 30, 30);
    repeat (3) frame(1'b0, 0, 0);
    chk("t4_waitb_anchor", {31'd0, o_anchor_vld}, 1);
    i_shape = 3'd2;
    tick(); tick();
    chk("t4_shape_change", {31'd0, o_anchor_vld}, 0);
    i_shape = 3'd1;
    push_pix(W - 1, H - 1, model_color, 1'b0);
    frame(1'b1, W - 1, H - 1);
    drain("t4_corner_dot", 50);

    // Clear rising mid-rect while the request is stalled.
    i_shape = 3'd3;
    frame(1'b1, 5, 5);
    repeat (3) frame(1'b0, 0, 0);
    ack_mode = 3;
    i_color  = 16'h7C1F;
    i_frame_end = 1'b1; i_hit = 1'b1; i_cur_x = 13'd9; i_cur_y = 13'd8;
    tick();
    i_frame_end = 1'b0; i_hit = 1'b0;
    model_color = 16'h7C1F;
    n = 0;
    while (!o_wr_req && n < 20) begin tick(); n++; end
    chk("t5_req_up", {31'd0, o_wr_req}, 1);
    allow_drop = 1'b1;
    i_clear = 1'b1;
    tick();
    chk("t5_req_dropped", {31'd0, o_wr_req}, 0);
    chk("t5_busy", {31'd0, o_busy}, 1);
    chk("t5_anchor", {31'd0, o_anchor_vld}, 0);
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) push_pix(x, y, 16'h0000, 1'b1);
    ack_mode = 0;
    drain("t5_clear", W * H + 200);
    allow_drop = 1'b0;
    i_clear = 1'b0;
    tick();

    // Reset in the middle of a slow line.
    ack_mode = 1;
    i_shape  = 3'd2;
    frame(1'b1, 0, 0);
    repeat (3) frame(1'b0, 0, 0);
    i_color = 16'h001F;
    push_line(0, 0, 40, 17, 16'h001F);
    frame(1'b1, 40, 17);
    n = 0;
    while (exp_q.size() > 38 && n < 400) begin tick(); n++; end
    chk("t6_progress", {31'd0, exp_q.size() <= 38}, 1);
    allow_drop = 1'b1;
    rst = 1'b0;
    tick();
    chk("t6_req", {31'd0, o_wr_req}, 0);
    chk("t6_busy", {31'd0, o_busy}, 0);
    chk("t6_anchor", {31'd0, o_anchor_vld}, 0);
    exp_q.delete();
    model_color = 16'hFFE0;
    rst = 1'b1;
    tick(); tick();
    allow_drop = 1'b0;
    ack_mode = 0;
    i_shape  = 3'd1;
    push_pix(7, 9, model_color, 1'b0);
    frame(1'b1, 7, 9);
    drain("t6_dot_after_reset", 50);

    // Randomized shapes, points, colours and acknowledge timing.
    ack_mode = 2;
    for (int t = 0; t < 14; t++) begin
      int          sh = $urandom_range(1, 3);
      int          ax = $urandom_range(0, W - 1);
      int          ay = $urandom_range(0, H - 1);
      int          bx = $urandom_range(0, W - 1);
      int          by = $urandom_range(0, H - 1);
      logic [15:0] c  = 16'($urandom);
      if (sh == 1) begin
        i_shape = 3'd1;
        i_color = c;
        push_pix(ax, ay, model_color, 1'b0);
        frame(1'b1, ax, ay);
        drain("rnd_dot", 100);
      end else begin
        two_point(sh == 2 ? "rnd_line" : "rnd_rect", 3'(sh), ax, ay, bx, by, c, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
